// File: rtl/vending_machine_if.sv
// Coin-acceptor side (coin/cancel levels) and dispenser/change-hopper side (one-cycle pulses).
// master drives coins and cancel; slave is the vending controller.
interface vending_machine_if;
    logic in1;
    logic in2;
    logic in5;
    logic cancel;
    logic vend;
    logic out1;
    logic out2;
    logic out22;

    modport master (
        output in1, in2, in5, cancel,
        input  vend, out1, out2, out22
    );

    modport slave (
        input  in1, in2, in5, cancel,
        output vend, out1, out2, out22
    );
endinterface

// File: rtl/vending_machine.sv
// Fixed-price ($4) vending controller taking $1/$2/$5 coins, with change and cancel refund.
// Latency: outputs registered, pulse one cycle after the detecting edge; no backpressure, pulses are fire-and-forget.
module vending_machine (
    input  logic              clk,
    input  logic              rst,
    vending_machine_if.slave  bus
);
    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;
    localparam logic [1:0] S3 = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       in1_prev;
    logic       in2_prev;
    logic       in5_prev;
    logic       cancel_prev;
    logic       ev1;
    logic       ev2;
    logic       ev5;
    logic       evc;
    logic [2:0] coin_val;
    logic [3:0] total;
    logic [2:0] change;
    logic       vend_nxt;

    assign ev1 = bus.in1    & ~in1_prev;
    assign ev2 = bus.in2    & ~in2_prev;
    assign ev5 = bus.in5    & ~in5_prev;
    assign evc = bus.cancel & ~cancel_prev;

    always_comb begin
        coin_val = 3'd0;
        if (ev5)
            coin_val = 3'd5;
        else if (ev2)
            coin_val = 3'd2;
        else if (ev1)
            coin_val = 3'd1;

        total     = {2'b00, state} + {1'b0, coin_val};
        state_nxt = state;
        vend_nxt  = 1'b0;
        change    = 3'd0;

        // Cancel outranks coins; same-cycle coins are dropped, not queued.
        if (evc) begin
            state_nxt = S0;
            change    = {1'b0, state};
        end else if (coin_val != 3'd0) begin
            if (total >= 4'd4) begin
                vend_nxt  = 1'b1;
                state_nxt = S0;
                // total is 4..8, so the low three bits minus 4 wrap to 0..4
                change    = total[2:0] - 3'd4;
            end else begin
                state_nxt = total[1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S0;
            in1_prev    <= 1'b0;
            in2_prev    <= 1'b0;
            in5_prev    <= 1'b0;
            cancel_prev <= 1'b0;
            bus.vend    <= 1'b0;
            bus.out1    <= 1'b0;
            bus.out2    <= 1'b0;
            bus.out22   <= 1'b0;
        end else begin
            state       <= state_nxt;
            in1_prev    <= bus.in1;
            in2_prev    <= bus.in2;
            in5_prev    <= bus.in5;
            cancel_prev <= bus.cancel;
            bus.vend    <= vend_nxt;
            bus.out1    <= (change == 3'd1) || (change == 3'd3);
            bus.out2    <= (change == 3'd2) || (change == 3'd3);
            bus.out22   <= (change == 3'd4);
        end
    end
endmodule

// File: tb/tb_vending_machine.sv
// Scoreboard bench: stimulus pushes expected {vend,out1,out2,out22} pulses, a negedge monitor pops and compares.
module tb_vending_machine;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vending_machine_if vif ();

    vending_machine dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    int compared   = 0;
    int mismatched = 0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;
    wire  [3:0] obs = {vif.vend, vif.out1, vif.out2, vif.out22};

    // Every nonzero output cycle must match the next queued pulse.
    always @(negedge clk) begin
        if (rst === 1'b1 && obs != 4'b0000) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_pulse: got %b, required no pulse", obs);
            end else begin
                mon_exp = exp_q.pop_front();
                if (obs !== mon_exp) begin
                    mismatched++;
                    $display("FAIL pulse: got %b, required %b", obs, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        vif.in1    = 1'b0;
        vif.in2    = 1'b0;
        vif.in5    = 1'b0;
        vif.cancel = 1'b0;
    endtask

    // v = 1, 2, 5 for coins, 0 for cancel; one cycle high then one low
    task automatic coin(input int v);
        case (v)
            1:       vif.in1    = 1'b1;
            2:       vif.in2    = 1'b1;
            5:       vif.in5    = 1'b1;
            default: vif.cancel = 1'b1;
        endcase
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic expect_pulse(input logic [3:0] e);
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        repeat (3) tick();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL %s: %0d expected pulses missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_now(input string name, input logic [3:0] e);
        compared++;
        if (obs !== e) begin
            mismatched++;
            $display("FAIL %s: got %b, required %b", name, obs, e);
        end
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_outputs", 4'b0000);
        rst = 1'b1;
        tick();

        // 1+1+2: exact price, no change
        coin(1); coin(1);
        expect_pulse(4'b1000);
        coin(2);
        drain("exact_price");

        // 5 from S0: change 1
        expect_pulse(4'b1100);
        coin(5);
        drain("five_from_s0");

        // 2+5: change 3
        coin(2);
        expect_pulse(4'b1110);
        coin(5);
        drain("two_then_five");

        // 1+1+1+5: change 4 as out22
        coin(1); coin(1); coin(1);
        expect_pulse(4'b1001);
        coin(5);
        drain("s3_plus_five");

        // credit 3 then cancel, then credit restarts at 0
        coin(1); coin(2);
        expect_pulse(4'b0110);
        coin(0);
        drain("cancel_refund3");
        coin(2);
        expect_pulse(4'b1000);
        coin(2);
        drain("after_cancel");

        // cancel at S0 refunds nothing
        coin(0);
        drain("cancel_s0");

        // in5 beats in1 in the same cycle; in1 is discarded
        expect_pulse(4'b1100);
        vif.in5 = 1'b1;
        vif.in1 = 1'b1;
        tick();
        clear_inputs();
        tick();
        drain("prio_5_over_1");

        // cancel beats in5: refund 2 only, state returns to S0
        coin(2);
        expect_pulse(4'b0010);
        vif.cancel = 1'b1;
        vif.in5    = 1'b1;
        tick();
        clear_inputs();
        tick();
        drain("prio_cancel_over_5");
        coin(2);
        expect_pulse(4'b1000);
        coin(2);
        drain("after_prio_cancel");

        // in1 held 1000 cycles counts once; in2 -> 3; in5 -> 8, change 4
        vif.in1 = 1'b1;
        repeat (1000) tick();
        vif.in2 = 1'b1;
        tick();
        vif.in2 = 1'b0;
        tick();
        expect_pulse(4'b1001);
        vif.in5 = 1'b1;
        tick();
        vif.in5 = 1'b0;
        tick();
        vif.in1 = 1'b0;
        drain("held_in1");

        // async reset truncates a pulse already on the outputs
        vif.in5 = 1'b1;
        tick();
        check_now("trunc_pulse_visible", 4'b1100);
        #2 rst = 1'b0;
        #1 check_now("trunc_async_clear", 4'b0000);
        vif.in5 = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        tick();
        drain("trunc_release");

        // reset at S3 loses credit: 1 -> S1, 2 -> S3, then 1 vends exactly
        coin(1); coin(1); coin(1);
        #2 rst = 1'b0;
        #1 check_now("reset_s3_outputs", 4'b0000);
        tick();
        tick();
        #2 rst = 1'b1;
        tick();
        coin(1);
        coin(2);
        drain("reset_s3_no_vend");
        expect_pulse(4'b1000);
        coin(1);
        drain("reset_s3_credit");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
